// File: rtl/vga_sync_gen.sv
// Free-running VGA/SVGA timing generator: h/v counters with sync, blank, de, frame_start (optional x/y via VGA_SYNC_COORD_EN).
// Latency: every output is a register aligned with hcount/vcount in the same cycle (zero skew between counters and flags).
// Backpressure: none; the block free-runs on clk_pixel, and a synchronous active-low rst_n returns it to 0,0.
module vga_sync_gen #(
    parameter int unsigned H_ACTIVE  = 800,
    parameter int unsigned H_FP      = 40,
    parameter int unsigned H_SYNC    = 128,
    parameter int unsigned H_BP      = 88,
    parameter int unsigned V_ACTIVE  = 600,
    parameter int unsigned V_FP      = 1,
    parameter int unsigned V_SYNC    = 4,
    parameter int unsigned V_BP      = 23,
    parameter bit          HSYNC_POL = 1'b1,
    parameter bit          VSYNC_POL = 1'b1,
    parameter int unsigned CW        = 11
) (
    input  logic          clk_pixel,
    input  logic          rst_n,
    output logic          hsync,
    output logic          vsync,
    output logic          hblank,
    output logic          vblank,
    output logic          de,
    output logic          frame_start,
    output logic [CW-1:0] hcount,
    output logic [CW-1:0] vcount
`ifdef VGA_SYNC_COORD_EN
    ,
    output logic [9:0]    x,
    output logic [9:0]    y
`endif
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_MAX      = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_MAX      = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_END  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_END  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_FIRST   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_LAST    = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_LAST    = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Every flop resets to 0, and sync/de/frame_start are stored in whichever
    // sense makes 0 equal to the reset state. iCE40 flops power up at 0, so the
    // block starts at the reset state even with rst_n tied high.
    logic [CW-1:0] hcount_q, hcount_d;
    logic [CW-1:0] vcount_q, vcount_d;
    logic          hblank_q, hblank_d;
    logic          vblank_q, vblank_d;
    logic          hsync_act_q, hsync_act_d;     // 1 = sync asserted
    logic          vsync_act_q, vsync_act_d;
    logic          de_n_q, de_n_d;               // inverted display enable
    logic          fs_n_q, fs_n_d;               // inverted frame_start
    logic          h_wrap;
    logic          v_wrap;
`ifdef VGA_SYNC_COORD_EN
    logic [9:0]    x_q, x_d;
    logic [9:0]    y_q, y_d;
`endif

    // Next counter state, then every flag derived from the next counters so the
    // registered flags line up with the registered counters.
    always_comb begin
        h_wrap   = (hcount_q == H_MAX);
        v_wrap   = (vcount_q == V_MAX);
        hcount_d = h_wrap ? '0 : hcount_q + 1'b1;
        vcount_d = vcount_q;
        if (h_wrap) begin
            vcount_d = v_wrap ? '0 : vcount_q + 1'b1;
        end
        hblank_d    = (hcount_d >= H_ACT_END);
        vblank_d    = (vcount_d >= V_ACT_END);
        de_n_d      = hblank_d || vblank_d;
        hsync_act_d = (hcount_d >= HS_FIRST) && (hcount_d <= HS_LAST);
        vsync_act_d = (vcount_d >= VS_FIRST) && (vcount_d <= VS_LAST);
        fs_n_d      = !((hcount_d == '0) && (vcount_d == '0));
`ifdef VGA_SYNC_COORD_EN
        x_d = de_n_d ? 10'd0 : 10'(hcount_d);
        y_d = de_n_d ? 10'd0 : 10'(vcount_d);
`endif
    end

    // State registers; reset parks the raster at 0,0 with syncs deasserted.
    always_ff @(posedge clk_pixel) begin
        if (!rst_n) begin
            hcount_q    <= '0;
            vcount_q    <= '0;
            hblank_q    <= 1'b0;
            vblank_q    <= 1'b0;
            hsync_act_q <= 1'b0;
            vsync_act_q <= 1'b0;
            de_n_q      <= 1'b0;
            fs_n_q      <= 1'b0;
`ifdef VGA_SYNC_COORD_EN
            x_q         <= '0;
            y_q         <= '0;
`endif
        end else begin
            hcount_q    <= hcount_d;
            vcount_q    <= vcount_d;
            hblank_q    <= hblank_d;
            vblank_q    <= vblank_d;
            hsync_act_q <= hsync_act_d;
            vsync_act_q <= vsync_act_d;
            de_n_q      <= de_n_d;
            fs_n_q      <= fs_n_d;
`ifdef VGA_SYNC_COORD_EN
            x_q         <= x_d;
            y_q         <= y_d;
`endif
        end
    end

    // Output polarity is a constant inversion straight off the flops.
    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign hblank      = hblank_q;
    assign vblank      = vblank_q;
    assign de          = !de_n_q;
    assign frame_start = !fs_n_q;
    assign hsync       = hsync_act_q ? HSYNC_POL : !HSYNC_POL;
    assign vsync       = vsync_act_q ? VSYNC_POL : !VSYNC_POL;
`ifdef VGA_SYNC_COORD_EN
    assign x           = x_q;
    assign y           = y_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen on a reduced raster (32 clocks x 20 lines = 640 clocks per frame).
// Horizontal: active 0..15, front porch 16..19, sync 20..27, back porch 28..31.
// Vertical: active 0..11, front porch 12, sync 13..16, back porch 17..19. A second instance uses inverted sync polarity.
module tb_vga_sync_gen;

    localparam int CW = 11;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          hsync, vsync, hblank, vblank, de, frame_start;
    logic [CW-1:0] hcount, vcount;
    logic          hsync_i, vsync_i, hblank_i, vblank_i, de_i, frame_start_i;
    logic [CW-1:0] hcount_i, vcount_i;
`ifdef VGA_SYNC_COORD_EN
    logic [9:0]    x, y, x_i, y_i;
`endif

    vga_sync_gen #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(12), .V_FP(1), .V_SYNC(4), .V_BP(3),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CW(CW)
    ) dut (
        .clk_pixel(clk), .rst_n(rst_n),
        .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank),
        .de(de), .frame_start(frame_start), .hcount(hcount), .vcount(vcount)
`ifdef VGA_SYNC_COORD_EN
        , .x(x), .y(y)
`endif
    );

    vga_sync_gen #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(12), .V_FP(1), .V_SYNC(4), .V_BP(3),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CW(CW)
    ) dut_inv (
        .clk_pixel(clk), .rst_n(rst_n),
        .hsync(hsync_i), .vsync(vsync_i), .hblank(hblank_i), .vblank(vblank_i),
        .de(de_i), .frame_start(frame_start_i), .hcount(hcount_i), .vcount(vcount_i)
`ifdef VGA_SYNC_COORD_EN
        , .x(x_i), .y(y_i)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int eh, ev;
        int seq_bad, flag_bad, inv_bad;
        int de_cnt, hs_cnt, hs_pulses, vs_cnt, fs_cnt;
        int hb_rise_h, hs_first_h, hs_last_h, vb_rise_h, vb_rise_v, vs_rise_h, vs_rise_v;
        logic prev_hs, prev_hb, prev_vb, prev_vs;
        logic e_hb, e_vb, e_hs, e_vs, e_de, e_fs;
`ifdef VGA_SYNC_COORD_EN
        int coord_bad;
        coord_bad = 0;
`endif
        seq_bad = 0; flag_bad = 0; inv_bad = 0;
        de_cnt = 0; hs_cnt = 0; hs_pulses = 0; vs_cnt = 0; fs_cnt = 0;
        hb_rise_h = -1; hs_first_h = -1; hs_last_h = -1;
        vb_rise_h = -1; vb_rise_v = -1; vs_rise_h = -1; vs_rise_v = -1;
        prev_hs = 1'b0; prev_hb = 1'b0; prev_vb = 1'b0; prev_vs = 1'b0;

        // Power-up state with rst_n held high, before the first edge.
        #1;
        check("pu_hcount", int'(hcount), 0);
        check("pu_vcount", int'(vcount), 0);
        check("pu_frame_start", int'(frame_start), 1);
        check("pu_de", int'(de), 1);
        check("pu_hsync", int'(hsync), 0);
        check("pu_vsync", int'(vsync), 0);
        check("pu_hblank", int'(hblank), 0);
        check("pu_vblank", int'(vblank), 0);
        check("pu_hsync_inv", int'(hsync_i), 1);
        check("pu_vsync_inv", int'(vsync_i), 1);

        // One whole frame from power-up, states 0..639.
        for (int i = 0; i < 640; i++) begin
            if (i > 0) step();
            eh   = i % 32;
            ev   = i / 32;
            e_hb = (eh >= 16);
            e_vb = (ev >= 12);
            e_hs = (eh >= 20) && (eh <= 27);
            e_vs = (ev >= 13) && (ev <= 16);
            e_de = !e_hb && !e_vb;
            e_fs = (i == 0);
            if (int'(hcount) != eh || int'(vcount) != ev) seq_bad++;
            if (hblank !== e_hb || vblank !== e_vb || hsync !== e_hs || vsync !== e_vs ||
                de !== e_de || frame_start !== e_fs) flag_bad++;
            if (hsync_i !== !hsync || vsync_i !== !vsync || hblank_i !== hblank ||
                vblank_i !== vblank || de_i !== de || frame_start_i !== frame_start ||
                hcount_i !== hcount || vcount_i !== vcount) inv_bad++;
            de_cnt += int'(de);
            hs_cnt += int'(hsync);
            vs_cnt += int'(vsync);
            fs_cnt += int'(frame_start);
            if (hsync && !prev_hs) hs_pulses++;
            if (hsync && hs_first_h < 0) hs_first_h = int'(hcount);
            if (hsync && vcount == '0) hs_last_h = int'(hcount);
            if (hblank && !prev_hb && hb_rise_h < 0) hb_rise_h = int'(hcount);
            if (vblank && !prev_vb && vb_rise_v < 0) begin
                vb_rise_v = int'(vcount);
                vb_rise_h = int'(hcount);
            end
            if (vsync && !prev_vs && vs_rise_v < 0) begin
                vs_rise_v = int'(vcount);
                vs_rise_h = int'(hcount);
            end
            prev_hs = hsync; prev_hb = hblank; prev_vb = vblank; prev_vs = vsync;
`ifdef VGA_SYNC_COORD_EN
            if (int'(x) != (e_de ? eh : 0) || int'(y) != (e_de ? ev : 0)) coord_bad++;
            if (i == 11 * 32 + 15) begin
                check("coord_last_x", int'(x), 15);
                check("coord_last_y", int'(y), 11);
            end
            if (i == 11 * 32 + 16) begin
                check("coord_blank_x", int'(x), 0);
                check("coord_blank_y", int'(y), 0);
            end
`endif
        end
        check("frame_counter_sequence_errs", seq_bad, 0);
        check("frame_flag_errs", flag_bad, 0);
        check("frame_inv_pol_errs", inv_bad, 0);
        check("de_cycles_per_frame", de_cnt, 192);
        check("hsync_cycles_per_frame", hs_cnt, 160);
        check("hsync_pulses_per_frame", hs_pulses, 20);
        check("vsync_cycles_per_frame", vs_cnt, 128);
        check("frame_start_pulses", fs_cnt, 1);
        check("hblank_rise_hcount", hb_rise_h, 16);
        check("hsync_first_hcount", hs_first_h, 20);
        check("hsync_last_hcount", hs_last_h, 27);
        check("vblank_rise_vcount", vb_rise_v, 12);
        check("vblank_rise_hcount", vb_rise_h, 0);
        check("vsync_rise_vcount", vs_rise_v, 13);
        check("vsync_rise_hcount", vs_rise_h, 0);
`ifdef VGA_SYNC_COORD_EN
        check("coord_errs", coord_bad, 0);
`endif

        // State 640: the frame wraps and frame_start pulses again, 640 clocks later.
        step();
        check("wrap_hcount", int'(hcount), 0);
        check("wrap_vcount", int'(vcount), 0);
        check("wrap_frame_start", int'(frame_start), 1);

        // Advance into the sync corner (line 14, pixel 22), where both syncs are asserted.
        for (int i = 0; i < 14 * 32 + 22; i++) step();
        check("pre_rst_hcount", int'(hcount), 22);
        check("pre_rst_vcount", int'(vcount), 14);
        check("pre_rst_hsync", int'(hsync), 1);
        check("pre_rst_vsync", int'(vsync), 1);

        // Mid-frame reset, held low for 3 clocks.
        rst_n = 1'b0;
        step();
        check("rst_hcount", int'(hcount), 0);
        check("rst_vcount", int'(vcount), 0);
        check("rst_hsync", int'(hsync), 0);
        check("rst_vsync", int'(vsync), 0);
        check("rst_hsync_inv", int'(hsync_i), 1);
        check("rst_de", int'(de), 1);
        check("rst_frame_start", int'(frame_start), 1);
        check("rst_hblank", int'(hblank), 0);
        check("rst_vblank", int'(vblank), 0);
        step();
        step();
        check("rst_hold_hcount", int'(hcount), 0);
        check("rst_hold_frame_start", int'(frame_start), 1);

        // Release: counting resumes on the first edge with rst_n high.
        rst_n = 1'b1;
        step();
        check("post_rst_hcount", int'(hcount), 1);
        check("post_rst_vcount", int'(vcount), 0);
        check("post_rst_frame_start", int'(frame_start), 0);
        check("post_rst_de", int'(de), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Free-running VGA/SVGA timing generator for the iCE40 video path.
- Horizontal and vertical counters on the pixel clock produce hsync, vsync, hblank, vblank, a display-enable and a frame-start pulse.
- Defaults give 800x600@60 Hz on a 40 MHz pixel clock: 1056 clocks per line, 628 lines, 663,168 clocks (16.579 ms) per frame.
- Pixel generators and RAM fetch logic downstream use the counters and blank flags.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (clocks)
- H_SYNC, 128, horizontal sync width (clocks)
- H_BP, 88, horizontal back porch (clocks)
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vertical sync width (lines)
- V_BP, 23, vertical back porch (lines)
- HSYNC_POL, 1, hsync asserted level (1 = active-high)
- VSYNC_POL, 1, vsync asserted level (1 = active-high)
- CW, 11, counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk_pixel  in   1   pixel clock; all logic on its rising edge
- rst_n      in   1   synchronous active-low reset
- hsync      out  1   horizontal sync, level per HSYNC_POL
- vsync      out  1   vertical sync, level per VSYNC_POL
- hblank     out  1   1 when hcount >= H_ACTIVE
- vblank     out  1   1 when vcount >= V_ACTIVE
- de         out  1   display enable = !hblank && !vblank
- frame_start out 1   one-clock pulse when hcount==0 && vcount==0
- hcount     out  CW  current horizontal position
- vcount     out  CW  current line

Behaviour:
- One clock (clk_pixel); reset is synchronous and active-low (rst_n), sampled on the rising clk_pixel edge.
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1056). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (628).
- hcount increments every clock and wraps H_TOTAL-1 -> 0.
- vcount increments only on the clock where hcount wraps; it wraps V_TOTAL-1 -> 0 when both counters are at their maximum.
- All outputs are registered and consistent with hcount/vcount in the same cycle: zero skew between counters and flags.
- hsync asserted for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 840..967. Deasserted level = !HSYNC_POL.
- vsync asserted for vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 601..604, for the whole of each of those lines (changes at hcount==0).
- hblank covers 800..1055; vblank covers 600..627.
- Reset (rst_n=0 at an edge), including mid-frame: hcount=0, vcount=0, hblank=0, vblank=0, de=1, frame_start=1.
- After reset, hsync and vsync are at their deasserted levels. Counting resumes on the first edge with rst_n=1.
- Power-up register initial values equal the reset values, so the block runs correctly with rst_n tied high.
- frame_start is high exactly one clock per frame, including the clock in which reset holds the counters at 0,0.
- No out-of-range counter states are reachable; comparisons are unsigned, CW bits wide.

Optional Feature:
- Macro VGA_SYNC_COORD_EN.
- When defined, adds outputs x (10 bits) and y (10 bits). They equal hcount/vcount during active video and are held at 0 during blanking.
- They are also registered and aligned with de.
- When not defined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
- rst_n low 3 clocks, then high -> hcount=0, vcount=0, frame_start=1, de=1, hsync=vsync=0; next clock hcount=1, frame_start=0.
- Run one line -> hblank rises at hcount=800. hsync=1 for hcount 840..967, exactly 128 clocks (3.2 us at 25 ns). hcount wraps 1055->0 with vcount 0->1.
- Run 17 ms with rst_n=1 from power-up -> vblank rises at vcount=600. vsync high for 4 lines, 4224 clocks, starting at vcount=601, hcount=0. frame_start pulses again 663,168 clocks after the first.
- Assert rst_n low at vcount=300, hcount=500 -> next edge: counters 0,0, hsync/vsync deasserted, de=1.
- Count de=1 cycles over one frame -> 480,000 (800x600). Count hsync pulses per frame -> 628.
- With VGA_SYNC_COORD_EN: at hcount=799, vcount=599 -> x=799, y=599. At hcount=800 -> x=0, y=0.
